// File: rtl/krnl_local_sp_arbiter.sv
// Write/read arbiter in front of a single-port memory with a credit-limited read-response FIFO.
// Build option: define LOCAL_SP_ARB_WRITE_PRIO_EN for fixed write priority (default is round-robin).
module krnl_local_sp_arbiter #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int RdLatency    = 2,
  parameter int RspDepth     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [AddressWidth-1:0] w_addr,
  input  logic [DataWidth-1:0]    w_data,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [AddressWidth-1:0] r_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_data,
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0
);

  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam int SumW = CntW + 1;

  logic [CntW-1:0]      inflight;
  logic [CntW-1:0]      fifo_cnt;
  logic [SumW-1:0]      credit_used;
  logic                 credit_ok;
  logic                 r_elig;
  logic                 win_w;
  logic                 w_acc;
  logic                 r_acc;
  logic                 rd_issue;
  logic [RdLatency-1:0] rd_vld_p;
  logic                 push;
  logic                 pop;
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [DataWidth-1:0] fifo_mem [RspDepth];

  // A read slot is reserved from acceptance until its response is popped.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit_ok   = credit_used < SumW'(RspDepth);
  assign r_elig      = r_valid & credit_ok;

`ifdef LOCAL_SP_ARB_WRITE_PRIO_EN
  assign win_w = 1'b1;
`else
  logic last_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_w <= 1'b0;
    end else if (w_acc || r_acc) begin
      last_w <= w_acc;
    end
  end

  assign win_w = ~last_w;
`endif

  // The loser of a contention sees ready low and must hold its request.
  always_comb begin
    w_ready = 1'b0;
    r_ready = 1'b0;
    if (reset) begin
      w_ready = ~(r_elig & ~win_w);
      r_ready = credit_ok & ~(w_valid & win_w);
    end
  end

  assign w_acc = w_valid & w_ready;
  assign r_acc = r_valid & r_ready;

  // ---- stage p0: registered memory command, one cycle after acceptance ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ce0      <= 1'b0;
      mem_we0      <= 1'b0;
      mem_address0 <= '0;
      mem_d0       <= '0;
    end else begin
      mem_ce0 <= w_acc | r_acc;
      mem_we0 <= w_acc;
      if (w_acc) begin
        mem_address0 <= w_addr;
        mem_d0       <= w_data;
      end else if (r_acc) begin
        mem_address0 <= r_addr;
      end
    end
  end

  assign rd_issue = mem_ce0 & ~mem_we0;

  // ---- stages p1..pN: read valid tracks the memory latency ----
  if (RdLatency > 1) begin : g_shift
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_vld_p <= '0;
      end else begin
        rd_vld_p <= {rd_vld_p[RdLatency-2:0], rd_issue};
      end
    end
  end else begin : g_single
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_vld_p <= '0;
      end else begin
        rd_vld_p <= rd_issue;
      end
    end
  end

  assign push = rd_vld_p[RdLatency-1];
  assign pop  = rsp_valid & rsp_ready;

  // ---- response FIFO: control is reset, storage is not ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + CntW'(r_acc) - CntW'(push);
      fifo_cnt <= fifo_cnt + CntW'(push) - CntW'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_q0;
    end
  end

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_krnl_local_sp_arbiter.sv
// Directed bench for krnl_local_sp_arbiter: memory model, read scoreboard, port and handshake checks.
module tb_krnl_local_sp_arbiter;

  localparam int DW   = 256;
  localparam int AW   = 11;
  localparam int RDL  = 2;
  localparam int RSPD = 4;
  localparam int MEMW = 2 ** AW;

  logic          clk;
  logic          reset;
  logic          w_valid;
  logic          w_ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          r_valid;
  logic          r_ready;
  logic [AW-1:0] r_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0;
  logic          mem_we0;
  logic [DW-1:0] mem_d0;
  logic [DW-1:0] mem_q0;

  krnl_local_sp_arbiter #(
    .DataWidth(DW), .AddressWidth(AW), .RdLatency(RDL), .RspDepth(RSPD)
  ) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  int            checks;
  int            errors;
  int            cyc;
  exp_t          sb[$];
  bit            glog[$];
  logic [DW-1:0] tb_mem  [MEMW];
  logic [DW-1:0] ref_mem [MEMW];
  logic [DW-1:0] q_pipe  [RDL];

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory with RDL cycles of read latency.
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) tb_mem[mem_address0] = mem_d0;
    if (mem_ce0 && !mem_we0) q_pipe[0] <= tb_mem[mem_address0];
    else q_pipe[0] <= {8{32'hDEADBEEF}};
    for (int k = 1; k < RDL; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign mem_q0 = q_pipe[RDL-1];

  task automatic check_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: memory command, response order/data/latency, stall stability, credit.
  logic          prev_w, prev_r, prev_stall;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_d, prev_data;

  always @(negedge clk) begin
    bit   wa, ra;
    exp_t e;
    if (!reset) begin
      prev_w = 1'b0; prev_r = 1'b0; prev_stall = 1'b0;
      exp_addr = '0; exp_d = '0;
    end else begin
      check_n("mem_ce0", 32'(mem_ce0), 32'(prev_w | prev_r));
      check_n("mem_we0", 32'(mem_we0), 32'(prev_w));
      check_n("mem_address0", 32'(mem_address0), 32'(exp_addr));
      check_w("mem_d0", mem_d0, exp_d);
      if (prev_stall) begin
        check_n("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check_w("rsp_hold_data", rsp_data, prev_data);
      end
      wa = w_valid && w_ready;
      ra = r_valid && r_ready;
      check_n("one_grant", 32'(wa & ra), 32'd0);
      if (ra) check_n("credit", 32'(sb.size() < RSPD), 32'd1);
      if (rsp_valid && rsp_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL rsp_unexpected: observed response %h, expected none", rsp_data);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_w("rsp_data", rsp_data, e.data);
          check_n("rsp_latency_ok", 32'(cyc - e.cyc >= 2 + RDL), 32'd1);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      if (wa) begin
        ref_mem[w_addr] = w_data;
        exp_addr = w_addr;
        exp_d    = w_data;
        glog.push_back(1'b1);
      end
      if (ra) begin
        e.data = ref_mem[r_addr];
        e.cyc  = cyc;
        sb.push_back(e);
        exp_addr = r_addr;
        glog.push_back(1'b0);
      end
      prev_w = wa;
      prev_r = ra;
    end
  end

  // Both tasks are entered and left 1 time unit after a rising edge.
  task automatic issue_read(input logic [AW-1:0] a, input int maxc, output bit ok);
    ok = 1'b0;
    r_valid = 1'b1; r_addr = a;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk); ok = r_ready;
      @(posedge clk); #1;
    end
    r_valid = 1'b0;
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int maxc,
                             output bit ok);
    ok = 1'b0;
    w_valid = 1'b1; w_addr = a; w_data = d;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk); ok = w_ready;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    bit         acc;
    int         nacc;
    int         seen;
    logic [5:0] gl;
    logic [5:0] gexp;
    for (int i = 0; i < MEMW; i++) begin
      tb_mem[i]  = {8{32'(i) * 32'h9E3779B1}};
      ref_mem[i] = tb_mem[i];
    end
    reset = 1'b0; w_valid = 1'b1; r_valid = 1'b1;
    w_addr = '0; w_data = '0; r_addr = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_n("rst_ce0", 32'(mem_ce0), 0);
    check_n("rst_we0", 32'(mem_we0), 0);
    check_n("rst_addr", 32'(mem_address0), 0);
    check_w("rst_d0", mem_d0, '0);
    check_n("rst_rsp_valid", 32'(rsp_valid), 0);
    check_n("rst_w_ready", 32'(w_ready), 0);
    check_n("rst_r_ready", 32'(r_ready), 0);
    w_valid = 1'b0; r_valid = 1'b0;
    @(posedge clk); #4; reset = 1'b1;
    @(posedge clk); #1;

    // Contention straight out of reset
    w_addr = AW'(20); w_data = {8{32'hC0DE0020}}; r_addr = AW'(21);
    glog.delete();
    w_valid = 1'b1; r_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1; w_valid = 1'b0; r_valid = 1'b0;
    check_n("grant_count", 32'(glog.size()), 32'd6);
    gl = '0;
    for (int i = 0; i < 6 && i < glog.size(); i++) gl[5-i] = glog[i];
`ifdef LOCAL_SP_ARB_WRITE_PRIO_EN
    gexp = 6'b111111;
`else
    gexp = 6'b101010;
`endif
    check_n("grant_pattern", 32'(gl), 32'(gexp));
    repeat (12) @(posedge clk); #1;
    check_n("drain_contention", 32'(sb.size()), 0);

    // Write 0x5A to 7, read it back with exact timing
    issue_write(AW'(7), DW'(32'h5A), 4, ok);
    check_n("wr7_acc", 32'(ok), 1);
    check_n("wr7_ce0", 32'(mem_ce0), 1);
    check_n("wr7_we0", 32'(mem_we0), 1);
    check_n("wr7_addr", 32'(mem_address0), 7);
    check_w("wr7_d0", mem_d0, DW'(32'h5A));
    @(posedge clk); #1;
    check_n("idle_ce0", 32'(mem_ce0), 0);
    repeat (3) @(posedge clk); #1;
    issue_read(AW'(7), 4, ok);
    check_n("rd7_acc", 32'(ok), 1);
    check_n("rd7_we0", 32'(mem_we0), 0);
    check_n("rd7_ce0", 32'(mem_ce0), 1);
    check_n("rd7_t1_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check_n("rd7_t2_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check_n("rd7_t3_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check_n("rd7_t4_valid", 32'(rsp_valid), 1);
    check_w("rd7_t4_data", rsp_data, DW'(32'h5A));
    repeat (4) @(posedge clk); #1;

    // Back-to-back write then read of the same address
    issue_write(AW'(30), {8{32'h3030ABCD}}, 4, ok);
    check_n("wr30_acc", 32'(ok), 1);
    issue_read(AW'(30), 4, ok);
    check_n("rd30_acc", 32'(ok), 1);
    repeat (10) @(posedge clk); #1;
    check_n("drain_raw", 32'(sb.size()), 0);

    // Reads 1,2,3 back-to-back with rsp_ready toggling
    rsp_ready = 1'b1; r_valid = 1'b1; r_addr = AW'(1); nacc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); acc = r_valid && r_ready;
      @(posedge clk); #1;
      rsp_ready = ~rsp_ready;
      if (acc) begin
        nacc++;
        if (nacc == 3) r_valid = 1'b0;
        else r_addr = r_addr + AW'(1);
      end
    end
    r_valid = 1'b0; rsp_ready = 1'b1;
    check_n("toggle_acc", 32'(nacc), 3);
    repeat (4) @(posedge clk); #1;
    check_n("drain_toggle", 32'(sb.size()), 0);

    // Credit limit with responses blocked
    rsp_ready = 1'b0; nacc = 0;
    for (int i = 0; i < 6; i++) begin
      issue_read(AW'(40 + i), 8, ok);
      if (ok) nacc++;
    end
    check_n("credit_acc", 32'(nacc), RSPD);
    check_n("credit_r_ready", 32'(r_ready), 0);
    check_n("credit_rsp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_n("credit_freed", 32'(r_ready), 1);
    issue_read(AW'(46), 4, ok);
    check_n("credit_extra_acc", 32'(ok), 1);
    check_n("credit_full_again", 32'(r_ready), 0);
    rsp_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    check_n("drain_credit", 32'(sb.size()), 0);

    // Credits exhausted, then concurrent fill and drain with random backpressure
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_read(AW'(50 + i), 4, ok);
      check_n("fill_acc", 32'(ok), 1);
    end
    repeat (8) @(posedge clk); #1;
    check_n("full_r_ready", 32'(r_ready), 0);
    r_valid = 1'b1; r_addr = AW'(60); nacc = 0;
    for (int i = 0; i < 300 && nacc < 12; i++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk); acc = r_ready;
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        r_addr = r_addr + AW'(1);
      end
    end
    r_valid = 1'b0; rsp_ready = 1'b1;
    check_n("stream_acc", 32'(nacc), 12);
    repeat (12) @(posedge clk); #1;
    check_n("drain_stream", 32'(sb.size()), 0);

    // Reset with two reads in flight
    issue_read(AW'(10), 4, ok);
    check_n("inflight_a", 32'(ok), 1);
    issue_read(AW'(11), 4, ok);
    check_n("inflight_b", 32'(ok), 1);
    w_valid = 1'b1; w_addr = AW'(5);
    reset = 1'b0;
    sb.delete();
    #1;
    check_n("arst_ce0", 32'(mem_ce0), 0);
    check_n("arst_we0", 32'(mem_we0), 0);
    check_n("arst_addr", 32'(mem_address0), 0);
    check_w("arst_d0", mem_d0, '0);
    check_n("arst_rsp_valid", 32'(rsp_valid), 0);
    check_n("arst_w_ready", 32'(w_ready), 0);
    check_n("arst_r_ready", 32'(r_ready), 0);
    repeat (2) @(posedge clk); #4;
    reset = 1'b1; w_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_n("no_rsp_after_reset", 32'(seen), 0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/krnl_local_sp_arbiter.md
KRNL_LOCAL_SP_ARBITER -- requirements
Module: krnl_local_sp_arbiter

Interface
REQ-001 The block SHALL have parameter DataWidth, default 256, memory word width in bits.
REQ-002 The block SHALL have parameter AddressWidth, default 11, memory address width (2048 words).
REQ-003 The block SHALL have parameter RdLatency, default 2, cycles from mem_ce0 high (read) to valid mem_q0, range 1..4.
REQ-004 The block SHALL have parameter RspDepth, default 4, read-response FIFO entries, power of two, 2..16.
REQ-005 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports w_valid/w_ready, input/output, 1 each, write requester handshake.
REQ-008 The block SHALL have ports w_addr/w_data, input, AddressWidth/DataWidth, write address and data.
REQ-009 The block SHALL have ports r_valid/r_ready, input/output, 1 each, read requester handshake, plus r_addr, input, AddressWidth.
REQ-010 The block SHALL have ports rsp_valid/rsp_ready, output/input, 1 each, plus rsp_data, output, DataWidth, read response stream.
REQ-011 The block SHALL have ports mem_address0, mem_ce0, mem_we0, mem_d0, outputs, AddressWidth/1/1/DataWidth, driving the single-port memory.
REQ-012 The block SHALL have port mem_q0, input, DataWidth, memory read data.

Function
REQ-013 Request accepted when valid and ready both high at a rising edge; at most one request (read or write) accepted per cycle.
REQ-014 r_ready SHALL be high only when outstanding reads plus FIFO occupancy < RspDepth (credit rule).
REQ-015 When only one requester is eligible, it SHALL be granted that cycle; eligible = valid and (writes always; reads only with a credit).
REQ-016 When both eligible, grant SHALL round-robin: the requester not granted last SHALL win; last-grant register resets to "read" (write wins first contention).
REQ-017 w_ready/r_ready SHALL be combinational from valids, credits and last-grant; the loser sees ready low and holds its request.
REQ-018 Accepted request SHALL appear on memory ports registered, exactly one cycle after acceptance: mem_ce0=1, mem_we0=1 for write, 0 for read, address/data captured.
REQ-019 mem_ce0 and mem_we0 SHALL be 0 in every cycle with no accepted request in the previous cycle; mem_d0/mem_address0 hold last value.
REQ-020 A RdLatency-deep valid shift register SHALL track reads; mem_q0 captured into the FIFO exactly RdLatency cycles after mem_ce0 with mem_we0=0.
REQ-021 Read accepted at cycle T SHALL produce rsp_valid no earlier than T+2+RdLatency; responses in request order.
REQ-022 FIFO push and pop in the same cycle SHALL both take effect; credit freed on pop; pointers wrap modulo RspDepth.
REQ-023 rsp_data SHALL hold stable while rsp_valid high and rsp_ready low.
REQ-024 Write to address A accepted before a read of A SHALL be visible to that read (program order through single port).

Reset
REQ-025 Reset asserted asynchronously SHALL force mem_ce0=0, mem_we0=0, mem_address0=0, mem_d0=0, rsp_valid=0, FIFO empty, shift register clear, last-grant=read.
REQ-026 Reads in flight at reset SHALL be discarded; no response after deassertion.
REQ-027 w_ready/r_ready SHALL be 0 while reset asserted.

Configuration
REQ-028 Macro LOCAL_SP_ARB_WRITE_PRIO_EN defined: write SHALL win every contention (fixed priority), last-grant unused.
REQ-029 Macro undefined: round-robin per REQ-016.

Verification
REQ-030 Write 0x5A at addr 7, later read addr 7, RdLatency=2 -> mem_we0=1 cycle T+1; rsp_valid at read T'+4, rsp_data 0x5A.
REQ-031 Both valid continuously 6 cycles -> grants W,R,W,R,W,R (macro undefined); W x6 with macro defined.
REQ-032 rsp_ready held low, 6 reads issued -> exactly 4 accepted, r_ready low; one pop -> one more accepted.
REQ-033 Reads addrs 1,2,3 back-to-back with rsp_ready toggling 1,0 -> responses in order, data stable while stalled.
REQ-034 Reset asserted with 2 reads in flight -> all outputs at reset values immediately; no rsp_valid after release.
REQ-035 Simultaneous push and pop with FIFO full -> occupancy stays 4, no data lost.
